// File: rtl/spi_shadow_regbank.sv
// SPI-fed register bank: oversampled 3-wire SPI frames (address then data, MSB first)
// land in shadow registers and are committed to the active outputs on a frame strobe.
module spi_shadow_regbank #(
    parameter int NUM_REGS   = 8,
    parameter int REG_W      = 16,
    parameter int ADDR_W     = 4,
    parameter int DOUBLE_BUF = 1
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_csb,
    input  logic                      i_sclk,
    input  logic                      i_mosi,
    input  logic                      i_commit,
    input  logic                      i_err_clr,
    output logic [NUM_REGS*REG_W-1:0] o_regs,
    output logic                      o_pending,
    output logic                      o_busy,
    output logic                      o_err
);

    localparam int FRAME_W = ADDR_W + REG_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [ADDR_W:0] NUM_REGS_L = NUM_REGS[ADDR_W:0];

    localparam logic [2:0] ST_WAIT_IDLE = 3'd0;
    localparam logic [2:0] ST_IDLE      = 3'd1;
    localparam logic [2:0] ST_SHIFT     = 3'd2;
    localparam logic [2:0] ST_WRITE     = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    logic               csb_meta, csb_sync;
    logic               sclk_meta, sclk_sync, sclk_prev;
    logic               mosi_meta, mosi_sync;
    logic               sclk_rise;
    logic [2:0]         state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [FRAME_W-1:0] shift_reg;
    logic [ADDR_W-1:0]  wr_addr;
    logic [REG_W-1:0]   wr_data;
    logic               addr_ok, do_write, bad_addr, short_frame;
    logic [REG_W-1:0]   shadow [NUM_REGS];
    logic [REG_W-1:0]   active [NUM_REGS];
    logic               pending;

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            csb_meta  <= 1'b0;
            csb_sync  <= 1'b0;
            sclk_meta <= 1'b0;
            sclk_sync <= 1'b0;
            sclk_prev <= 1'b0;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            csb_meta  <= i_csb;
            csb_sync  <= csb_meta;
            sclk_meta <= i_sclk;
            sclk_sync <= sclk_meta;
            sclk_prev <= sclk_sync;
            mosi_meta <= i_mosi;
            mosi_sync <= mosi_meta;
        end
    end

    assign sclk_rise   = sclk_sync & ~sclk_prev;
    assign wr_addr     = shift_reg[FRAME_W-1 -: ADDR_W];
    assign wr_data     = shift_reg[REG_W-1:0];
    assign addr_ok     = {1'b0, wr_addr} < NUM_REGS_L;
    assign do_write    = (state == ST_WRITE) && addr_ok;
    assign bad_addr    = (state == ST_WRITE) && !addr_ok;
    assign short_frame = (state == ST_SHIFT) && csb_sync;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= ST_WAIT_IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            case (state)
                // A frame already underway at reset release is skipped until csb goes high.
                ST_WAIT_IDLE: if (csb_sync) state <= ST_IDLE;
                ST_IDLE: begin
                    if (!csb_sync) begin
                        state   <= ST_SHIFT;
                        bit_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (csb_sync) begin
                        state <= ST_IDLE;
                    end else if (sclk_rise) begin
                        shift_reg <= {shift_reg[FRAME_W-2:0], mosi_sync};
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == CNT_W'(FRAME_W - 1)) state <= ST_WRITE;
                    end
                end
                ST_WRITE: state <= ST_DONE;
                ST_DONE:  if (csb_sync) state <= ST_IDLE;
                default:  state <= ST_WAIT_IDLE;
            endcase
        end
    end

    // NOTE: the register arrays are reset explicitly because o_regs must read 0 after reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
            pending <= 1'b0;
        end else if (DOUBLE_BUF != 0) begin
            // Commit copies pre-write shadow; a coinciding write stays pending.
            if (i_commit && pending) begin
                for (int k = 0; k < NUM_REGS; k++) active[k] <= shadow[k];
                pending <= 1'b0;
            end
            for (int k = 0; k < NUM_REGS; k++)
                if (do_write && wr_addr == ADDR_W'(k)) shadow[k] <= wr_data;
            if (do_write) pending <= 1'b1;
        end else begin
            for (int k = 0; k < NUM_REGS; k++)
                if (do_write && wr_addr == ADDR_W'(k)) active[k] <= wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)                       o_err <= 1'b0;
        else if (short_frame || bad_addr)  o_err <= 1'b1;
        else if (i_err_clr)                o_err <= 1'b0;
    end

    // NOTE: default assignment first so the combinational block can never infer a latch.
    always_comb begin
        o_regs = '0;
        for (int k = 0; k < NUM_REGS; k++) o_regs[k*REG_W +: REG_W] = active[k];
    end

    assign o_pending = pending;
    assign o_busy    = (state == ST_SHIFT);

endmodule

// File: tb/tb_spi_shadow_regbank.sv
// Directed bench for spi_shadow_regbank: one double-buffered and one direct-mode instance
// share sclk/mosi/commit but have separate chip selects.
module tb_spi_shadow_regbank;

    logic         clk = 1'b0;
    logic         reset, csb_a, csb_b, sclk, mosi, commit, err_clr;
    logic [127:0] regs_a, regs_b;
    logic         pend_a, busy_a, err_a, pend_b, busy_b, err_b;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    spi_shadow_regbank dut_a (
        .i_clk(clk), .i_reset(reset), .i_csb(csb_a), .i_sclk(sclk), .i_mosi(mosi),
        .i_commit(commit), .i_err_clr(err_clr),
        .o_regs(regs_a), .o_pending(pend_a), .o_busy(busy_a), .o_err(err_a)
    );

    spi_shadow_regbank #(.DOUBLE_BUF(0)) dut_b (
        .i_clk(clk), .i_reset(reset), .i_csb(csb_b), .i_sclk(sclk), .i_mosi(mosi),
        .i_commit(commit), .i_err_clr(err_clr),
        .o_regs(regs_b), .o_pending(pend_b), .o_busy(busy_b), .o_err(err_b)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] reg_of(input logic [127:0] v, input int k);
        return v[k*16 +: 16];
    endfunction

    task automatic set_csb(input bit sel_b, input logic v);
        if (sel_b) csb_b = v;
        else       csb_a = v;
    endtask

    task automatic begin_frame(input bit sel_b);
        set_csb(sel_b, 1'b0);
        repeat (4) @(negedge clk);
    endtask

    task automatic end_frame(input bit sel_b);
        sclk = 1'b0;
        repeat (4) @(negedge clk);
        set_csb(sel_b, 1'b1);
        repeat (6) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b);
        mosi = b;
        sclk = 1'b0;
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) spi_bit(v[i]);
    endtask

    // Last bit: return 3 edges after the sclk rise, i.e. just after the capture edge E.
    task automatic spi_last_rise(input logic b);
        mosi = b;
        sclk = 1'b0;
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_frame(input bit sel_b, input logic [31:0] v, input int n);
        begin_frame(sel_b);
        spi_bits(v, n);
        end_frame(sel_b);
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        reset = 1'b1; csb_a = 1'b1; csb_b = 1'b1; sclk = 1'b0; mosi = 1'b0;
        commit = 1'b0; err_clr = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_regs", regs_a, '0);
        check("reset_pending", pend_a, 1'b0);
        check("reset_busy", busy_a, 1'b0);
        check("reset_err", err_a, 1'b0);

        // Basic write: lands in shadow only until committed.
        send_frame(1'b0, 32'h3BEEF, 20);
        check("basic_reg3_before_commit", reg_of(regs_a, 3), 16'h0000);
        check("basic_pending_set", pend_a, 1'b1);
        check("basic_err_clear", err_a, 1'b0);
        pulse_commit();
        check("basic_regs_after_commit", regs_a, 128'h0000_0000_0000_0000_BEEF_0000_0000_0000);
        check("basic_pending_cleared", pend_a, 1'b0);

        // Batch commit: both writes appear at the same edge.
        send_frame(1'b0, 32'h01234, 20);
        send_frame(1'b0, 32'h7FFFF, 20);
        check("batch_regs_before_commit", regs_a, 128'h0000_0000_0000_0000_BEEF_0000_0000_0000);
        pulse_commit();
        check("batch_regs_after_commit", regs_a, 128'hFFFF_0000_0000_0000_BEEF_0000_0000_1234);
        check("batch_pending_cleared", pend_a, 1'b0);

        // Commit collision on the WRITE edge.
        send_frame(1'b0, 32'h10001, 20);
        check("collide_pending_before", pend_a, 1'b1);
        begin_frame(1'b0);
        spi_bits(32'h10002 >> 1, 19);
        spi_last_rise(1'b0);
        pulse_commit();
        check("collide_reg1_old_value", reg_of(regs_a, 1), 16'h0001);
        check("collide_pending_kept", pend_a, 1'b1);
        end_frame(1'b0);
        pulse_commit();
        check("collide_regs_second_commit", regs_a, 128'hFFFF_0000_0000_0000_BEEF_0000_0002_1234);
        check("collide_pending_cleared", pend_a, 1'b0);

        // Out-of-range address.
        send_frame(1'b0, 32'h91234, 20);
        check("badaddr_regs_unchanged", regs_a, 128'hFFFF_0000_0000_0000_BEEF_0000_0002_1234);
        check("badaddr_err_set", err_a, 1'b1);
        check("badaddr_no_pending", pend_a, 1'b0);
        pulse_err_clr();
        check("errclr_after_badaddr", err_a, 1'b0);

        // Short frame terminated by csb.
        begin_frame(1'b0);
        spi_bits(32'h00ABC, 12);
        sclk = 1'b0;
        repeat (4) @(negedge clk);
        check("short_busy_mid_frame", busy_a, 1'b1);
        end_frame(1'b0);
        check("short_busy_released", busy_a, 1'b0);
        check("short_err_set", err_a, 1'b1);
        check("short_regs_unchanged", regs_a, 128'hFFFF_0000_0000_0000_BEEF_0000_0002_1234);
        pulse_err_clr();
        check("errclr_after_short", err_a, 1'b0);

        // Reset after 10 bits; the tail of that frame must not write.
        begin_frame(1'b0);
        spi_bits(32'h66666 >> 10, 10);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        spi_bits(32'h66666, 10);
        end_frame(1'b0);
        check("midreset_regs_zero", regs_a, '0);
        check("midreset_no_pending", pend_a, 1'b0);
        check("midreset_no_err", err_a, 1'b0);
        send_frame(1'b0, 32'h200A5, 20);
        check("after_reset_pending", pend_a, 1'b1);
        pulse_commit();
        check("after_reset_regs", regs_a, 128'h0000_0000_0000_0000_0000_00A5_0000_0000);

        // Over-length frame: first 20 bits count, no error.
        send_frame(1'b0, {7'b0, 20'h40F0F, 5'b10101}, 25);
        check("overlen_err_clear", err_a, 1'b0);
        check("overlen_pending", pend_a, 1'b1);
        pulse_commit();
        check("overlen_regs", regs_a, 128'h0000_0000_0000_0F0F_0000_00A5_0000_0000);

        // Direct mode: write visible at E+1, no pending, commit ignored.
        begin_frame(1'b1);
        spi_bits(32'h55A5A >> 1, 19);
        spi_last_rise(1'b0);
        check("direct_reg5_at_e", reg_of(regs_b, 5), 16'h0000);
        @(negedge clk);
        check("direct_reg5_at_e1", reg_of(regs_b, 5), 16'h5A5A);
        check("direct_pending_zero", pend_b, 1'b0);
        end_frame(1'b1);
        pulse_commit();
        check("direct_regs_after_commit", regs_b, 128'h0000_0000_5A5A_0000_0000_0000_0000_0000);
        check("direct_pending_after_commit", pend_b, 1'b0);
        check("direct_err_clear", err_b, 1'b0);
        check("double_buf_untouched", regs_a, 128'h0000_0000_0000_0F0F_0000_00A5_0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
